// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// vote-point placement and the default oversampling ratio.
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Baud_rate instances feeding this receiver run at DEF_OVERSAMPLE * baud.
  localparam int DEF_OVERSAMPLE = 16;

  // Votes are taken at center-VOTE_SPREAD, center and center+VOTE_SPREAD.
  localparam int VOTE_SPREAD = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for uart_rx_os: 2-flop synchronizer, arm flag and the
// 3-sample majority voter around the bit center.
module uart_rx_sampler
  import uart_rx_os_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int CW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          rx,
  input  logic [CW-1:0] cnt,
  output logic          rx_s,
  output logic          arm,
  output logic          bit_val,
  output logic          vote_done
);

  localparam int            CENTER  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] V_FIRST = CW'(CENTER - VOTE_SPREAD);
  localparam logic [CW-1:0] V_MID   = CW'(CENTER);
  localparam logic [CW-1:0] V_LAST  = CW'(CENTER + VOTE_SPREAD);

  logic rx_meta;
  logic s_first;
  logic s_mid;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      arm     <= 1'b0;
      s_first <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (tick) begin
        // arm holds the line level seen at the previous tick: a falling edge
        // only counts as a start once the line has been observed high.
        arm <= rx_s;
        if (cnt == V_FIRST) s_first <= rx_s;
        if (cnt == V_MID)   s_mid   <= rx_s;
      end
    end
  end

  assign vote_done = tick && (cnt == V_LAST);
  assign bit_val   = maj3(s_first, s_mid, rx_s);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority voting, optional parity, framing
// and overrun detection, delivering bytes through a valid/ready holding register.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IW-1:0]        bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_acc, par_acc_d;
  logic                 perr_acc, perr_acc_d;
  logic                 ferr_acc, ferr_acc_d;
  logic                 complete, cmpl_q;
  logic                 rx_s, arm, bit_val, vote_done;
  logic                 bit_end, hs;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .CW(CW)) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .rx       (rx),
    .cnt      (cnt),
    .rx_s     (rx_s),
    .arm      (arm),
    .bit_val  (bit_val),
    .vote_done(vote_done)
  );

  assign bit_end = tick && (cnt == CNT_LAST);
  assign hs      = valid && ready_in;
  assign busy    = (state != IDLE);

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shift_d    = shift;
    par_acc_d  = par_acc;
    perr_acc_d = perr_acc;
    ferr_acc_d = ferr_acc;
    complete   = 1'b0;
    if (state == IDLE)  cnt_d = '0;
    else if (bit_end)   cnt_d = '0;
    else if (tick)      cnt_d = cnt + 1'b1;
    else                cnt_d = cnt;

    unique case (state)
      IDLE: begin
        if (tick && arm && !rx_s) begin
          state_d    = START;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_acc_d  = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (vote_done && bit_val) state_d = IDLE;
        else if (bit_end)         state_d = DATA;
      end
      DATA: begin
        if (vote_done) begin
          shift_d   = {bit_val, shift[DATA_BITS-1:1]};
          par_acc_d = par_acc ^ bit_val;
        end
        if (bit_end) begin
          if (bit_idx == IDX_LAST) state_d = PARITY_EN ? PARITY : STOP;
          else                     bit_idx_d = bit_idx + 1'b1;
        end
      end
      PARITY: begin
        if (vote_done) perr_acc_d = (bit_val != (par_acc ^ PARITY_ODD));
        if (bit_end)   state_d = STOP;
      end
      STOP: begin
        if (vote_done) begin
          if (!bit_val) ferr_acc_d = 1'b1;
          // Finish at the vote so a start edge right after the stop bit is caught.
          if (stop_idx == STOP_LAST) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        if (bit_end && state_d == STOP) stop_idx_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_acc  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      cmpl_q   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shift    <= shift_d;
      par_acc  <= par_acc_d;
      perr_acc <= perr_acc_d;
      ferr_acc <= ferr_acc_d;
      cmpl_q   <= complete;
    end
  end

  // Holding register: shift/perr_acc/ferr_acc are still stable in the cycle
  // after completion because the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (cmpl_q) begin
      if (!valid || hs) begin
        data_out   <= shift;
        frame_err  <= ferr_acc;
        parity_err <= perr_acc;
        overrun    <= 1'b0;
        valid      <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (hs) begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 instance plus an even-parity instance,
// serial frames driven by hand with a fast tick (one tick every 4 clk).
module tb_uart_rx_os;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       ready_in = 1'b1;
  logic [7:0] data_out, data_out_p;
  logic       valid, frame_err, parity_err, overrun, busy;
  logic       valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int   n_vec = 0;
  int   n_miss = 0;
  int   hs_cnt = 0, hs_cnt_p = 0, busy_cnt = 0;
  rec_t last_rec = '0, last_rec_p = '0;

  uart_rx_os dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_out(data_out), .valid(valid), .ready_in(ready_in),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_os #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_p),
    .data_out(data_out_p), .valid(valid_p), .ready_in(ready_in),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  always #10 clk = ~clk;

  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      div  = (div == TICK_DIV - 1) ? 0 : div + 1;
      tick = (div == 0);
    end
  end

  // Handshake and busy monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (valid && ready_in) begin
      hs_cnt++;
      last_rec = {data_out, frame_err, parity_err, overrun};
    end
    if (valid_p && ready_in) begin
      hs_cnt_p++;
      last_rec_p = {data_out_p, frame_err_p, parity_err_p, overrun_p};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (with_par) drive_bit(sel, par);
    drive_bit(sel, stop);
    if (sel) rx_p = 1'b1;
    else     rx = 1'b1;
  endtask

  initial begin
    int hs0, busy0;

    // Reset state
    step(5);
    @(negedge clk);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", 32'({frame_err, parity_err, overrun}), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(2 * BIT_CLKS);

    // Clean frame 0x0B
    hs0 = hs_cnt;
    send_frame(1'b0, 8'h0B, 1'b0, 1'b0, 1'b1);
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("b0b_count", 32'(hs_cnt - hs0), 32'd1);
    check("b0b_data", 32'(last_rec.d), 32'h0B);
    check("b0b_errs", 32'({last_rec.fe, last_rec.pe, last_rec.ov}), 32'h0);
    check("b0b_valid_clr", 32'(valid), 32'h0);

    // Short low glitch: false start, no delivery
    hs0 = hs_cnt; busy0 = busy_cnt;
    step(1);
    rx = 1'b0;
    step(4 * TICK_DIV);
    rx = 1'b1;
    step(BIT_CLKS - 4 * TICK_DIV);
    @(negedge clk);
    check("glitch_busy_rose", 32'(busy_cnt > busy0), 32'd1);
    check("glitch_busy_now", 32'(busy), 32'h0);
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("glitch_no_valid", 32'(hs_cnt - hs0), 32'd0);

    // 0xA5 with stop=0, then a 20-bit break
    hs0 = hs_cnt;
    step(1);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    busy0 = busy_cnt;
    step(20 * BIT_CLKS);
    @(negedge clk);
    check("brk_count", 32'(hs_cnt - hs0), 32'd1);
    check("brk_data", 32'(last_rec.d), 32'hA5);
    check("brk_ferr", 32'(last_rec.fe), 32'h1);
    check("brk_busy_quiet", 32'(busy_cnt - busy0), 32'd0);
    step(1);
    rx = 1'b1;
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("brk_no_reframe", 32'(hs_cnt - hs0), 32'd1);

    // Back-to-back 0x55, 0xAA with no consumer
    step(1);
    ready_in = 1'b0;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
    step(BIT_CLKS);
    @(negedge clk);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_data", 32'(data_out), 32'h55);
    check("ovr_flag", 32'(overrun), 32'h1);
    hs0 = hs_cnt;
    step(1);
    ready_in = 1'b1;
    step(1);
    ready_in = 1'b0;
    @(negedge clk);
    check("ovr_hs_count", 32'(hs_cnt - hs0), 32'd1);
    check("ovr_hs_rec", 32'(last_rec), 32'({8'h55, 1'b0, 1'b0, 1'b1}));
    check("ovr_valid_clr", 32'(valid), 32'h0);
    check("ovr_flag_clr", 32'(overrun), 32'h0);

    // Reset during data bit 3 of 0xFF with an earlier byte still held
    step(1);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    step(BIT_CLKS);
    @(negedge clk);
    check("prerst_valid", 32'(valid), 32'h1);
    check("prerst_data", 32'(data_out), 32'h81);
    step(1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    step(BIT_CLKS / 2);
    check("prerst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    step(4);
    rst_n = 1'b1;
    ready_in = 1'b1;
    step(2 * BIT_CLKS);
    hs0 = hs_cnt;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("post_rst_count", 32'(hs_cnt - hs0), 32'd1);
    check("post_rst_rec", 32'(last_rec), 32'({8'h3C, 3'b000}));

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    hs0 = hs_cnt_p;
    step(1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("par_bad_count", 32'(hs_cnt_p - hs0), 32'd1);
    check("par_bad_rec", 32'(last_rec_p), 32'({8'h07, 1'b0, 1'b1, 1'b0}));
    step(1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    step(2 * BIT_CLKS);
    @(negedge clk);
    check("par_ok_count", 32'(hs_cnt_p - hs0), 32'd2);
    check("par_ok_rec", 32'(last_rec_p), 32'({8'h07, 3'b000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
